// File: rtl/rgb_led_pkg.sv
// Shared types and colour constants for the RGB LED arbiter.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] OFF     = 3'b000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rgb_led_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner; pointer moves only on accept.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         grant_c,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_c
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand_c;
    logic          found_c;

    // First valid requester after ptr, wrapping modulo NUM_REQ; ptr itself is tried last.
    always_comb begin
        found_c     = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        grant_c     = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand_c = IW'((int'(ptr) + k) % int'(NUM_REQ));
            if (!found_c && req_valid[cand_c]) begin
                found_c     = 1'b1;
                grant_idx_c = cand_c;
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            grant_c[i] = enable && found_c && (grant_idx_c == IW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IW'(NUM_REQ - 1);
        end else if (enable && found_c) begin
            ptr <= grant_idx_c;
        end
    end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Shares one active-low RGB LED between NUM_REQ requesters: grant, hold, optional dark gap.
// Optional PWM dimming during SHOW when RGB_ARB_PWM_EN is defined.
module rgb_led_arbiter
    import rgb_led_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned HOLD_CYCLES = 12_000_000,
`ifdef RGB_ARB_PWM_EN
    parameter logic [7:0]  PWM_DUTY    = 8'd64,
`endif
    parameter int unsigned GAP_CYCLES  = 1_200_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [3*NUM_REQ-1:0]       req_color,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       RGB_R,
    output logic                       RGB_G,
    output logic                       RGB_B
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    color, color_d;
    logic [IW-1:0] grant_id_d;
    logic [IW-1:0] win_idx_c;
    logic [2:0]    win_color_c;
    logic [2:0]    pins_d;
    logic          busy_d;
    logic          arb_en_c;
    logic          accept_c;
    logic          dim_on_c;

    // Reset also masks ready so nothing is accepted while rst is held.
    assign arb_en_c = (state == IDLE) && !rst;
    assign accept_c = |req_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .enable      (arb_en_c),
        .req_valid   (req_valid),
        .grant_c     (req_ready),
        .grant_idx_c (win_idx_c)
    );

    always_comb begin
        win_color_c = OFF;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_idx_c == IW'(i)) begin
                win_color_c = req_color[3*i +: 3];
            end
        end
    end

`ifdef RGB_ARB_PWM_EN
    logic [7:0] pwm_cnt;
    logic [7:0] pwm_next_c;

    assign pwm_next_c = pwm_cnt + 8'd1;
    // Pins are registered, so compare against the value the counter holds next cycle.
    assign dim_on_c   = pwm_next_c < PWM_DUTY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 8'd0;
        end else begin
            pwm_cnt <= pwm_next_c;
        end
    end
`else
    assign dim_on_c = 1'b1;
`endif

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        color_d    = color;
        grant_id_d = grant_id;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_d    = SHOW;
                    cnt_d      = HOLD_LOAD;
                    color_d    = win_color_c;
                    grant_id_d = win_idx_c;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        pins_d = ((state_d == SHOW) && dim_on_c) ? ~color_d : 3'b111;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            cnt                   <= '0;
            color                 <= OFF;
            grant_id              <= '0;
            busy                  <= 1'b0;
            {RGB_R, RGB_G, RGB_B} <= 3'b111;
        end else begin
            state                 <= state_d;
            cnt                   <= cnt_d;
            color                 <= color_d;
            grant_id              <= grant_id_d;
            busy                  <= busy_d;
            {RGB_R, RGB_G, RGB_B} <= pins_d;
        end
    end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed, table-driven bench for rgb_led_arbiter (NUM_REQ=3, HOLD=4, GAP=2 and a GAP=0 twin).
module tb_rgb_led_arbiter;
    import rgb_led_pkg::*;

    typedef struct {
        logic [2:0] valid;
        logic [8:0] color;
        logic [2:0] ready;
        logic [2:0] pins;
        logic       busy;
        logic [1:0] gid;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] req_valid;
    logic [8:0] req_color;

    logic [2:0] ready_a, ready_z;
    logic [1:0] gid_a, gid_z;
    logic       busy_a, busy_z;
    logic       r_a, g_a, b_a, r_z, g_z, b_z;
    logic [2:0] pins_a, pins_z;

    assign pins_a = {r_a, g_a, b_a};
    assign pins_z = {r_z, g_z, b_z};

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    rgb_led_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_color(req_color),
        .req_ready(ready_a), .grant_id(gid_a), .busy(busy_a),
        .RGB_R(r_a), .RGB_G(g_a), .RGB_B(b_a)
    );

    rgb_led_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_color(req_color),
        .req_ready(ready_z), .grant_id(gid_z), .busy(busy_z),
        .RGB_R(r_z), .RGB_G(g_z), .RGB_B(b_z)
    );

`ifdef RGB_ARB_PWM_EN
    logic [1:0] pwm_valid;
    logic [5:0] pwm_color;
    logic [1:0] pwm_ready;
    logic       pwm_gid;
    logic       pwm_busy, pwm_r, pwm_g, pwm_b;

    rgb_led_arbiter #(.NUM_REQ(2), .HOLD_CYCLES(600), .PWM_DUTY(8'd64), .GAP_CYCLES(0)) dut_pwm (
        .clk(clk), .rst(rst), .req_valid(pwm_valid), .req_color(pwm_color),
        .req_ready(pwm_ready), .grant_id(pwm_gid), .busy(pwm_busy),
        .RGB_R(pwm_r), .RGB_G(pwm_g), .RGB_B(pwm_b)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int n, input logic [2:0] v, input logic [8:0] c,
                       input logic [2:0] r, input logic [2:0] p, input logic b,
                       input logic [1:0] g);
        vec_t e;
        e.valid = v; e.color = c; e.ready = r; e.pins = p; e.busy = b; e.gid = g;
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] c_rgb, c_cyan, c_off1;
        bit         seen;
        int         lows;
        c_rgb  = {BLUE, GREEN, RED};
        c_cyan = {CYAN, GREEN, RED};
        c_off1 = {CYAN, OFF, RED};

        // cycle-by-cycle trace, cycle 0 = first cycle after reset release
        add(1, 3'b111, c_rgb,  3'b001, 3'b111, 1'b0, 2'd0);
        add(4, 3'b111, c_rgb,  3'b000, 3'b011, 1'b1, 2'd0);
        add(2, 3'b111, c_rgb,  3'b000, 3'b111, 1'b1, 2'd0);
        add(1, 3'b111, c_rgb,  3'b010, 3'b111, 1'b0, 2'd0);
        add(4, 3'b111, c_rgb,  3'b000, 3'b101, 1'b1, 2'd1);
        add(2, 3'b111, c_rgb,  3'b000, 3'b111, 1'b1, 2'd1);
        add(1, 3'b111, c_rgb,  3'b100, 3'b111, 1'b0, 2'd1);
        add(4, 3'b111, c_rgb,  3'b000, 3'b110, 1'b1, 2'd2);
        add(2, 3'b111, c_rgb,  3'b000, 3'b111, 1'b1, 2'd2);
        add(1, 3'b111, c_rgb,  3'b001, 3'b111, 1'b0, 2'd2);
        add(4, 3'b100, c_cyan, 3'b000, 3'b011, 1'b1, 2'd0);
        add(2, 3'b100, c_cyan, 3'b000, 3'b111, 1'b1, 2'd0);
        add(1, 3'b100, c_cyan, 3'b100, 3'b111, 1'b0, 2'd0);
        add(4, 3'b100, c_cyan, 3'b000, 3'b100, 1'b1, 2'd2);
        add(2, 3'b100, c_cyan, 3'b000, 3'b111, 1'b1, 2'd2);
        add(1, 3'b100, c_cyan, 3'b100, 3'b111, 1'b0, 2'd2);
        add(1, 3'b100, c_cyan, 3'b000, 3'b100, 1'b1, 2'd2);
        add(3, 3'b000, c_cyan, 3'b000, 3'b100, 1'b1, 2'd2);
        add(2, 3'b000, c_cyan, 3'b000, 3'b111, 1'b1, 2'd2);
        add(2, 3'b000, c_cyan, 3'b000, 3'b111, 1'b0, 2'd2);
        add(1, 3'b010, c_off1, 3'b010, 3'b111, 1'b0, 2'd2);
        add(4, 3'b000, c_off1, 3'b000, 3'b111, 1'b1, 2'd1);
        add(1, 3'b000, c_off1, 3'b000, 3'b111, 1'b1, 2'd1);

        rst = 1'b1;
        req_valid = 3'b111;
        req_color = c_rgb;
`ifdef RGB_ARB_PWM_EN
        pwm_valid = 2'b01;
        pwm_color = {OFF, RED};
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pins", 32'(pins_a), 32'(3'b111));
        chk("reset_ready", 32'(ready_a), 32'(3'b000));
        chk("reset_busy", 32'(busy_a), 32'(1'b0));
        chk("reset_gid", 32'(gid_a), 32'(2'd0));
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            req_valid = tbl[i].valid;
            req_color = tbl[i].color;
            @(negedge clk);
            chk($sformatf("row%0d_ready", i), 32'(ready_a), 32'(tbl[i].ready));
            chk($sformatf("row%0d_pins", i), 32'(pins_a), 32'(tbl[i].pins));
            chk($sformatf("row%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("row%0d_gid", i), 32'(gid_a), 32'(tbl[i].gid));
            @(posedge clk); #1;
        end

        // requester 0 alone moves the pointer to 0; then reset asynchronously mid-SHOW
        req_valid = 3'b001;
        req_color = c_rgb;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (ready_a != 3'b000) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("wait_ready_r0", 32'(ready_a), 32'(3'b001));
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(posedge clk); #1;
        req_valid = 3'b111;
        #2;
        chk("midshow_pins", 32'(pins_a), 32'(3'b011));
        rst = 1'b1;
        #1;
        chk("async_pins", 32'(pins_a), 32'(3'b111));
        chk("async_busy", 32'(busy_a), 32'(1'b0));
        chk("async_ready", 32'(ready_a), 32'(3'b000));
        rst = 1'b0;

        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_ready_c%0d", c), 32'(ready_a),
                32'((c == 0) ? 3'b001 : (c == 7) ? 3'b010 : 3'b000));
            chk($sformatf("nogap_ready_c%0d", c), 32'(ready_z),
                32'((c == 0) ? 3'b001 : (c == 5) ? 3'b010 : (c == 10) ? 3'b100 : 3'b000));
            if (c == 1) begin
                chk("post_rst_pins", 32'(pins_a), 32'(3'b011));
                chk("post_rst_gid", 32'(gid_a), 32'(2'd0));
            end
            if (c == 4) chk("nogap_last_show_pins", 32'(pins_z), 32'(3'b011));
            if (c == 5) chk("nogap_idle_pins", 32'(pins_z), 32'(3'b111));
            if (c == 6) chk("nogap_gid", 32'(gid_z), 32'(2'd1));
        end

`ifdef RGB_ARB_PWM_EN
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        lows = 0;
        for (int c = 0; c < 512; c++) begin
            @(negedge clk);
            if (!pwm_busy) begin
                chk("pwm_busy", 32'(pwm_busy), 32'(1'b1));
            end
            if (!pwm_r) lows++;
            if (!pwm_g) chk("pwm_green_off", 32'(pwm_g), 32'(1'b1));
        end
        chk("pwm_red_low_count", 32'(lows), 32'd128);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the single on-board active-low RGB LED between several independent requesters, such as a status heartbeat, an error flag and a user-pattern generator. Each requester offers a 3-bit colour through a valid/ready handshake. A round-robin arbiter grants one requester at a time. The granted colour is shown for a fixed hold time, followed by an optional dark gap. The block sits between the colour-producing logic and the RGB_R/RGB_G/RGB_B pins.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters; legal range 2..8.
- HOLD_CYCLES, 12_000_000: clk cycles a granted colour is displayed; must be ≥1 (1 s at 12 MHz).
- GAP_CYCLES, 1_200_000: clk cycles the LED is dark after each hold; 0 skips the gap.
- PWM_DUTY, 8'd64: on-time out of 256 per PWM period; used only with RGB_ARB_PWM_EN.

Ports:
- clk, input, 1: 12 MHz system clock.
- rst, input, 1: reset, asynchronous, active-high.
- req_valid, input, NUM_REQ: bit i means requester i has a colour pending.
- req_color, input, 3*NUM_REQ: colour {r,g,b} for requester i at [3*i+:3]; 1 means on.
- req_ready, output, NUM_REQ: one-hot accept strobe; combinational.
- grant_id, output, $clog2(NUM_REQ): index of the requester whose colour is being shown.
- busy, output, 1: high in SHOW or GAP.
- RGB_R, output, 1: red LED pin, active-low.
- RGB_G, output, 1: green LED pin, active-low.
- RGB_B, output, 1: blue LED pin, active-low.

## Operation
- States:
  - IDLE: LED off; arbitrating.
  - SHOW: displaying the latched colour.
  - GAP: LED off.
- IDLE:
  - If any req_valid bit is set, req_ready[w] = 1 for the round-robin winner w. The transfer completes that cycle.
  - The block latches color = req_color[3*w+:3], sets grant_id = w and pointer = w, loads the counter with HOLD_CYCLES-1, and moves to SHOW.
  - With no requests, req_ready = 0 and the state stays IDLE.
- Round-robin search starts at pointer+1 and wraps modulo NUM_REQ. After reset pointer = NUM_REQ-1, so requester 0 wins first.
- SHOW: the counter decrements each cycle. When it reaches 0:
  - If GAP_CYCLES > 0, load GAP_CYCLES-1 and go to GAP.
  - Otherwise go to IDLE.
- GAP: the counter decrements each cycle; at 0 go to IDLE.
- req_ready is 0 in SHOW and GAP. Requesters hold valid and colour until they see ready.
- A requester may drop req_valid before it is granted; this is legal and the request is simply not served.
- Colour 3'b000 is a valid request: it holds the LED dark for the whole SHOW period.
- The counter is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits wide, and all loads are truncated to that width.

## Timing
- Reset values:
  - state = IDLE, pointer = NUM_REQ-1, counter = 0, colour = 3'b000.
  - grant_id = 0, busy = 0, RGB_R/RGB_G/RGB_B = 1 (off), req_ready = 0.
- All outputs except req_ready are registered.
- Accept in cycle N: LED pins show the colour from cycle N+1 through N+HOLD_CYCLES, and busy is high over the same span.
- Gap: LED is dark for cycles N+HOLD_CYCLES+1 through N+HOLD_CYCLES+GAP_CYCLES. The next accept is possible in cycle N+HOLD_CYCLES+GAP_CYCLES+1.
- Back-to-back grants to different requesters are therefore separated by exactly HOLD_CYCLES+GAP_CYCLES+1 cycles when requests are continuous.
- If rst asserts mid-SHOW or mid-GAP, the outputs go to their reset values immediately, without waiting for a clock edge.
- The first accept after rst deasserts is at the first rising edge of clk.

## Configuration
- RGB_ARB_PWM_EN defined:
  - A free-running 8-bit PWM counter is added; it resets to 0 and increments every cycle.
  - During SHOW, each on-colour bit drives its pin low only while pwm_cnt < PWM_DUTY, which dims the LED.
  - The PWM counter has no effect on state timing.
- RGB_ARB_PWM_EN undefined: the PWM counter and PWM_DUTY logic are absent, and SHOW drives the colour at full brightness.

## Structure
- Package rgb_led_pkg:
  - State enum: IDLE/SHOW/GAP.
  - Colour constants: RED=3'b100, YELLOW=3'b110, GREEN=3'b010, CYAN=3'b011, BLUE=3'b001, MAGENTA=3'b101, OFF=3'b000.
- One sub-module, rr_arbiter:
  - Takes req_valid and an enable (state==IDLE).
  - Produces a one-hot grant and a binary index.
  - Owns the pointer register, updated only on accept.
- The FSM, counter, colour latch and pin drive live in rgb_led_arbiter.

## Test plan
All scenarios use NUM_REQ=3, HOLD_CYCLES=4, GAP_CYCLES=2.
- Reset behaviour: assert rst with req_valid=3'b111 → pins=3'b111, req_ready=0, busy=0; deassert → req_ready=3'b001 at the first edge, and pins show req_color[2:0] for 4 cycles starting the following cycle.
- Continuous requests: req_valid=3'b111 held with colours RED/GREEN/BLUE → grants 0,1,2,0 in order, each accept 7 cycles apart; pins dark for 2 cycles between colours.
- Single requester: only req_valid[2] (CYAN) → grant_id=2 every 7 cycles; pins RGB = 3'b100 during SHOW.
- Reset mid-operation: pulse rst asynchronously (between edges) during SHOW cycle 2 → pins go to 3'b111 immediately; after release, requester 0 wins first again.
- Zero-gap and PWM: set GAP_CYCLES=0 → next accept in the cycle after SHOW ends (5-cycle spacing); define RGB_ARB_PWM_EN with PWM_DUTY=64 → red pin low for exactly 64 of every 256 SHOW cycles.
